// File: rtl/key_input_pkg.sv
// Shared types and sizing helpers for the pushbutton input front end.
// Imported by key_channel and key_input.
package key_input_pkg;

    // Per-key press tracking: not pressed, pressed, pressed long enough.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_t;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Debounce counter width.
    function automatic int db_cnt_width(input int debounce_cycles);
        return cnt_width(debounce_cycles);
    endfunction

    // Hold counter width.
    function automatic int hold_cnt_width(input int long_cycles);
        return cnt_width(long_cycles);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: synchronizer, polarity normalisation, debounce and press FSM.
// All outputs come straight from flops.
module key_channel
    import key_input_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DBW = db_cnt_width(DEBOUNCE_CYCLES);
    localparam int HW  = hold_cnt_width(LONG_CYCLES);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

    // Raw pin level that means "not pressed".
    localparam logic IDLE_RAW = ACTIVE_LOW;

    logic           sync0_q;
    logic           sync1_q;
    logic           pressed_q;

    logic           level_q;
    logic           level_d;
    logic [DBW-1:0] db_cnt_q;
    logic [DBW-1:0] db_cnt_d;
    logic           accept;

    key_state_t     state_q;
    key_state_t     state_d;
    logic [HW-1:0]  hold_cnt_q;
    logic [HW-1:0]  hold_cnt_d;
    logic           press_q;
    logic           press_d;
    logic           release_q;
    logic           release_d;
    logic           long_q;
    logic           long_d;

    logic           accept_press;
    logic           accept_release;

    // Bring the pin into the clock domain and normalise to 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q   <= IDLE_RAW;
            sync1_q   <= IDLE_RAW;
            pressed_q <= 1'b0;
        end else begin
            sync0_q   <= key_raw_i;
            sync1_q   <= sync0_q;
            pressed_q <= sync1_q ^ ACTIVE_LOW;
        end
    end

    // Accept a level change only after it has differed for the full window.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        accept   = 1'b0;
        if (pressed_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign accept_press   = accept & ~level_q;
    assign accept_release = accept &  level_q;

    // Press tracking: emit press/release on accepted edges, long once per press.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_press) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end
            end
            HELD: begin
                if (accept_release) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (accept_release) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Debounce and FSM state registers, plus the registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_input.sv
// Pushbutton front end: one independent debounce channel per key pin.
// Produces debounced levels and press/release/long-press pulses.
module key_input
    import key_input_pkg::*;
#(
    parameter int KEY_WIDTH       = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] KEY,
    output logic [KEY_WIDTH-1:0] key_level,
    output logic [KEY_WIDTH-1:0] key_press,
    output logic [KEY_WIDTH-1:0] key_release,
    output logic [KEY_WIDTH-1:0] key_long
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_input: DEBOUNCE_CYCLES must be at least 2");
    end

    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("key_input: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
        key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw_i (KEY[k]),
            .level_o   (key_level[k]),
            .press_o   (key_press[k]),
            .release_o (key_release[k]),
            .long_o    (key_long[k])
        );
    end

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: window-based reference model,
// directed scenarios with literal timing pins, then randomized key activity.
module tb_key_input;

    localparam int KW = 4;
    localparam int DB = 8;
    localparam int LG = 32;
    localparam int HL = DB + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] KEY = '1;
    logic [KW-1:0] key_level;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_long;

    key_input #(
        .KEY_WIDTH       (KW),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .KEY         (KEY),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    int press_edge [KW];
    int release_edge [KW];
    int long_edge [KW];
    int press_cnt [KW];
    int release_cnt [KW];
    int long_cnt [KW];

    // Model: hist[k][i] is the pressed sample taken at edge (now - i).
    bit            hist [KW][HL];
    logic [KW-1:0] m_level = '0;
    logic [KW-1:0] m_press = '0;
    logic [KW-1:0] m_release = '0;
    logic [KW-1:0] m_long = '0;
    int            m_age [KW];
    bit            m_armed [KW];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit flip;
        if (!rst_n) begin
            for (int k = 0; k < KW; k++) begin
                for (int i = 0; i < HL; i++) hist[k][i] = 1'b0;
                m_age[k] = 0;
                m_armed[k] = 1'b0;
            end
            m_level = '0;
            m_press = '0;
            m_release = '0;
            m_long = '0;
        end else begin
            for (int k = 0; k < KW; k++) begin
                for (int i = HL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = ~KEY[k];
                // A change is accepted once DB consecutive samples,
                // three edges old or older, all disagree with the level.
                flip = 1'b1;
                for (int i = 3; i < HL; i++)
                    if (hist[k][i] == m_level[k]) flip = 1'b0;
                m_press[k] = flip & ~m_level[k];
                m_release[k] = flip & m_level[k];
                m_long[k] = 1'b0;
                if (flip) m_level[k] = ~m_level[k];
                if (m_press[k]) begin
                    m_age[k] = 0;
                    m_armed[k] = 1'b1;
                end else if (m_level[k]) begin
                    m_age[k]++;
                    if (m_armed[k] && m_age[k] == LG) begin
                        m_long[k] = 1'b1;
                        m_armed[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Compare process: one model step per rising edge, checked mid-cycle.
    initial begin
        for (int k = 0; k < KW; k++) begin
            press_edge[k] = -1;
            release_edge[k] = -1;
            long_edge[k] = -1;
            press_cnt[k] = 0;
            release_cnt[k] = 0;
            long_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            ecount++;
            model_step();
            chk("key_level", 32'(key_level), 32'(m_level));
            chk("key_press", 32'(key_press), 32'(m_press));
            chk("key_release", 32'(key_release), 32'(m_release));
            chk("key_long", 32'(key_long), 32'(m_long));
            for (int k = 0; k < KW; k++) begin
                if (key_press[k]) begin
                    press_edge[k] = ecount;
                    press_cnt[k]++;
                end
                if (key_release[k]) begin
                    release_edge[k] = ecount;
                    release_cnt[k]++;
                end
                if (key_long[k]) begin
                    long_edge[k] = ecount;
                    long_cnt[k]++;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    int t0;
    int t1;
    int tr;
    int rb;
    int pc1;
    int pc2;
    int left [KW];

    initial begin
        wait_cyc(3);
        chk("reset_outputs", 32'({key_level, key_press, key_release, key_long}), 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Clean press on key 0.
        KEY[0] = 1'b0;
        t0 = ecount;
        wait_cyc(20);
        chk("clean_press_edge", 32'(press_edge[0]), 32'(t0 + 11));
        chk("clean_press_count", 32'(press_cnt[0]), 32'd1);
        chk("clean_level", 32'(key_level[0]), 32'd1);
        KEY[0] = 1'b1;
        wait_cyc(15);
        chk("clean_release_count", 32'(release_cnt[0]), 32'd1);

        // Bounce on key 1, every 3 cycles.
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) KEY[1] = ~KEY[1];
            wait_cyc(1);
        end
        KEY[1] = 1'b1;
        wait_cyc(15);
        chk("bounce_press", 32'(press_cnt[1]), 32'd0);
        chk("bounce_release", 32'(release_cnt[1]), 32'd0);
        chk("bounce_level", 32'(key_level[1]), 32'd0);

        // Long press on key 2.
        KEY[2] = 1'b0;
        t0 = ecount;
        wait_cyc(60);
        KEY[2] = 1'b1;
        t1 = ecount;
        wait_cyc(15);
        chk("long_press_edge", 32'(press_edge[2]), 32'(t0 + 11));
        chk("long_edge", 32'(long_edge[2]), 32'(t0 + 43));
        chk("long_count", 32'(long_cnt[2]), 32'd1);
        chk("long_release_edge", 32'(release_edge[2]), 32'(t1 + 11));

        // Short press on key 3.
        KEY[3] = 1'b0;
        wait_cyc(20);
        KEY[3] = 1'b1;
        wait_cyc(15);
        chk("short_press", 32'(press_cnt[3]), 32'd1);
        chk("short_release", 32'(release_cnt[3]), 32'd1);
        chk("short_long", 32'(long_cnt[3]), 32'd0);

        // Reset while key 0 is held.
        KEY[0] = 1'b0;
        wait_cyc(15);
        rb = release_cnt[0];
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({key_level, key_press, key_release, key_long}), 32'h0);
        wait_cyc(2);
        rst_n = 1'b1;
        tr = ecount;
        wait_cyc(15);
        chk("reset_repress_edge", 32'(press_edge[0]), 32'(tr + 11));
        chk("reset_no_release", 32'(release_cnt[0]), 32'(rb));
        KEY[0] = 1'b1;
        wait_cyc(15);

        // Keys 0 and 3 together.
        pc1 = press_cnt[1];
        pc2 = press_cnt[2];
        KEY = 4'b0110;
        t0 = ecount;
        wait_cyc(15);
        chk("conc_press0", 32'(press_edge[0]), 32'(t0 + 11));
        chk("conc_press3", 32'(press_edge[3]), 32'(t0 + 11));
        chk("conc_others", 32'(press_cnt[1] + press_cnt[2]), 32'(pc1 + pc2));
        KEY = '1;
        wait_cyc(15);

        // Randomized activity, with occasional resets.
        for (int k = 0; k < KW; k++) left[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < KW; k++) begin
                if (left[k] == 0) begin
                    KEY[k] = ~KEY[k];
                    left[k] = ($urandom_range(0, 2) != 0) ?
                              int'($urandom_range(1, 12)) :
                              int'($urandom_range(20, 70));
                end else begin
                    left[k]--;
                end
            end
            if (c % 1000 == 700) begin
                rst_n = 1'b0;
                wait_cyc(2);
                rst_n = 1'b1;
            end
            wait_cyc(1);
        end

        KEY = '1;
        wait_cyc(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
